// File: rtl/schoolbook_modred_pkg.sv
// Shared definitions for the bit-serial modular reducer: default width,
// counter sizing and the controller state encoding.
package schoolbook_pkg;

  localparam int N_DEF = 384;

  function automatic int cnt_w(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int CNT_W = cnt_w(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/schoolbook_modred_step.sv
// One restoring-reduction step: shift a product bit into the partial
// remainder, compare against the modulus and subtract when it fits.
module schoolbook_modred_step
  import schoolbook_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] acc,
  input  logic         bit_in,
  input  logic [N-1:0] m,
  output logic [N-1:0] acc_next
);

  logic [N:0] t_s;
  logic       ge_s;

  assign t_s  = {acc, bit_in};
  assign ge_s = (t_s >= {1'b0, m});

  // t - m is below m, so the low N bits of the difference are exact
  always_comb begin
    acc_next = t_s[N-1:0];
    if (ge_s) begin
      acc_next = t_s[N-1:0] - m;
    end else begin
      acc_next = t_s[N-1:0];
    end
  end

endmodule

// File: rtl/schoolbook_modred.sv
// Bit-serial restoring reduction r = c mod m with fixed 2N-cycle latency.
// Optional zero-modulus check enabled by SCHOOLBOOK_MODRED_ZERO_CHK_EN.
module schoolbook_modred
  import schoolbook_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] c,
  input  logic [N-1:0]   m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   r,
  output logic           err
);

  localparam int CW = cnt_w(N);

  state_t          state_r;
  state_t          state_nx_s;
  logic [2*N-1:0]  c_r;
  logic [N-1:0]    m_r;
  // the remainder never reaches m, so N bits hold the accumulator
  logic [N-1:0]    acc_r;
  logic [N-1:0]    acc_nx_s;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    r_r;
  logic            accept_s;
  logic            zero_m_s;
  logic            last_s;

  assign accept_s = in_valid && (state_r == IDLE);
  assign last_s   = (cnt_r == {CW{1'b0}});

`ifdef SCHOOLBOOK_MODRED_ZERO_CHK_EN
  logic err_r;

  assign zero_m_s = (m == {N{1'b0}});
  assign err      = err_r;

  // Zero-modulus flag, refreshed on every accepted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= zero_m_s;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign zero_m_s = 1'b0;
  assign err      = 1'b0;
`endif

  schoolbook_modred_step #(
    .N (N)
  ) u_step (
    .acc      (acc_r),
    .bit_in   (c_r[2*N-1]),
    .m        (m_r),
    .acc_next (acc_nx_s)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Controller next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = zero_m_s ? DONE : RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      RUN:     in_ready  = 1'b0;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign r = r_r;

  // Datapath: the product is shifted MSB-first, which is equivalent to
  // indexing c_reg[count] with a down-counter but needs no wide mux
  always_ff @(posedge clk) begin
    if (rst) begin
      c_r   <= {(2*N){1'b0}};
      m_r   <= {N{1'b0}};
      acc_r <= {N{1'b0}};
      cnt_r <= {CW{1'b0}};
      r_r   <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            c_r   <= c;
            m_r   <= m;
            acc_r <= {N{1'b0}};
            cnt_r <= CW'(2 * N - 1);
            r_r   <= zero_m_s ? {N{1'b0}} : r_r;
          end else begin
            r_r <= r_r;
          end
        end
        RUN: begin
          acc_r <= acc_nx_s;
          c_r   <= {c_r[2*N-2:0], 1'b0};
          if (last_s) begin
            r_r <= acc_nx_s;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          r_r <= r_r;
        end
        default: begin
          r_r <= r_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_schoolbook_modred.sv
// Randomized self-checking bench for schoolbook_modred; the reference model
// uses plain 2N-bit modulo arithmetic.
module tb_schoolbook_modred;

  localparam int N = 384;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] c;
  logic [N-1:0]   m;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   r;
  logic           err;

  int checks;
  int errors;

  schoolbook_modred #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c         (c),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] rand_c();
    logic [2*N-1:0] v;
    v = {(2*N){1'b0}};
    for (int i = 0; i < (2*N)/32; i++) v = {v[2*N-33:0], 32'($urandom())};
    return v;
  endfunction

  // random modulus of random bit length, never zero
  function automatic logic [N-1:0] rand_m();
    logic [N-1:0] v;
    logic [2*N-1:0] w;
    w = rand_c();
    v = w[N-1:0] >> $urandom_range(0, N - 1);
    if (v == {N{1'b0}}) v = {{(N-1){1'b0}}, 1'b1};
    return v;
  endfunction

  function automatic logic [N-1:0] model_r(input logic [2*N-1:0] cv, input logic [N-1:0] mv);
    logic [2*N-1:0] q;
    if (mv == {N{1'b0}}) begin
`ifdef SCHOOLBOOK_MODRED_ZERO_CHK_EN
      return {N{1'b0}};
`else
      return cv[N-1:0];
`endif
    end
    q = cv % {{N{1'b0}}, mv};
    return q[N-1:0];
  endfunction

  function automatic logic model_err(input logic [N-1:0] mv);
`ifdef SCHOOLBOOK_MODRED_ZERO_CHK_EN
    return (mv == {N{1'b0}});
`else
    return 1'b0;
`endif
  endfunction

  // edges after the accepting edge until out_valid is visible; a zero
  // modulus with the check enabled is already in DONE after the accept edge
  function automatic int model_lat(input logic [N-1:0] mv);
    if (model_err(mv)) return 0;
    return 2 * N;
  endfunction

  task automatic run_op(input logic [2*N-1:0] cv, input logic [N-1:0] mv,
                        input int hold, input string tag);
    logic [N-1:0] er;
    logic         ee;
    int           el;
    int           lat;
    int           busy_bad;
    int           hold_bad;
    er = model_r(cv, mv);
    ee = model_err(mv);
    el = model_lat(mv);
    @(negedge clk);
    c = cv; m = mv; in_valid = 1'b1; out_ready = (hold == 0);
    check_eq({tag, "_rdy_pre"}, N'(in_ready), N'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0; c = rand_c(); m = rand_m();
    lat = 0; busy_bad = 0;
    while (!out_valid && lat <= 3 * N) begin
      if (in_ready) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_bad++;
    check_eq({tag, "_valid"}, N'(out_valid), N'(1'b1));
    check_eq({tag, "_lat"}, N'(lat), N'(el));
    check_eq({tag, "_busy"}, N'(busy_bad), N'(0));
    check_eq({tag, "_r"}, r, er);
    check_eq({tag, "_err"}, N'(err), N'(ee));
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (r !== er || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== ee) hold_bad++;
    end
    check_eq({tag, "_hold"}, N'(hold_bad), N'(0));
    // a request in the handshake cycle must not be taken
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_rel_valid"}, N'(out_valid), N'(1'b0));
    check_eq({tag, "_rel_idle"}, N'(in_ready), N'(1'b1));
    check_eq({tag, "_rel_r"}, r, er);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    c = rand_c(); m = rand_m(); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2 * N - 1 - 200) @(posedge clk);
    #1;
    check_eq("midrst_busy", N'(in_ready), N'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_rdy", N'(in_ready), N'(1'b1));
    check_eq("midrst_valid", N'(out_valid), N'(1'b0));
    check_eq("midrst_r", r, {N{1'b0}});
    check_eq("midrst_err", N'(err), N'(1'b0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2*N-1:0] cv;
    logic [N-1:0]   mv;
    logic [2*N-1:0] mx;
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    c = {(2*N){1'b0}}; m = {N{1'b0}};
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy", N'(in_ready), N'(1'b1));
    check_eq("rst_valid", N'(out_valid), N'(1'b0));
    check_eq("rst_r", r, {N{1'b0}});
    check_eq("rst_err", N'(err), N'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    run_op((2*N)'(100), N'(7), 0, "small");
    mx = {{N{1'b0}}, {N{1'b1}}};
    run_op(mx * mx, {N{1'b1}}, 0, "maxsq");
    run_op(rand_c(), N'(1), 1, "m_one");
    run_op({(2*N){1'b0}}, rand_m(), 0, "c_zero");
    mv = rand_m();
    run_op({{N{1'b0}}, mv - N'(1)}, mv, 0, "c_m_minus1");
    run_op(rand_c(), rand_m(), 10, "backpress");

    reset_mid_run();
    run_op((2*N)'(100), N'(7), 0, "after_rst");

    for (int k = 0; k < 16; k++) begin
      cv = rand_c();
      if (k % 4 == 3) cv = cv >> $urandom_range(N, 2 * N - 1);
      run_op(cv, rand_m(), $urandom_range(0, 3), $sformatf("rnd%0d", k));
    end

    run_op(rand_c(), {N{1'b0}}, 2, "m_zero");
    run_op(rand_c(), rand_m(), 0, "post_zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/schoolbook_modred.md
Name: schoolbook_modred

Overview:
- Downstream stage of the schoolbook multiplier. Takes the 2N-bit product and an N-bit modulus, and returns the product mod the modulus.
- Uses bit-serial restoring reduction: one product bit per cycle, MSB first.
- Fixed, data-independent latency, so timing does not leak operand values.
- Sits between the multiplier output register and the consumer of modular results.

Parameters:
- N, 384, operand/modulus width; the product input is 2N bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product and modulus valid.
- in_ready  output  1  block can accept an operation.
- c  input  2N  product to reduce.
- m  input  N  modulus.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- r  output  N  c mod m.
- err  output  1  zero-modulus flag (see Optional Feature).

Behaviour:
- States:
  - IDLE: in_ready=1.
  - RUN.
  - DONE: out_valid=1.
- Reset, from any state including mid-RUN: state=IDLE, r=0, err=0, out_valid=0, accumulator=0, count=0. Any operation in flight is discarded.
- IDLE->RUN on in_valid&&in_ready:
  - latch c into c_reg and m into m_reg;
  - clear accumulator acc (N+1 bits);
  - count=2N-1.
  - Later changes on c/m are ignored.
- RUN, each cycle:
  - t = {acc[N-1:0], c_reg[count]};
  - if t >= {1'b0,m_reg} then acc = t - m_reg, else acc = t.
  - N+1 bits suffice because acc < m always holds.
  - When count==0, go to DONE and load r = acc[N-1:0]; otherwise decrement count.
- Latency:
  - out_valid rises exactly 2N rising edges after the accepting edge (768 for N=384);
  - the latency is independent of the data.
- DONE:
  - r and out_valid are held stable until out_ready=1;
  - on the out_ready edge go to IDLE and drop out_valid; r keeps its value.
- in_ready is low in RUN and DONE. If in_valid is asserted in the same cycle as the DONE handshake, it is not accepted; it may be accepted in the following IDLE cycle.
- Minimum throughput is one operation per 2N+2 cycles.
- No requirement on m parity or on m's MSB; any m >= 1 is supported. c >= m^2 is legal.

Optional Feature:
- Macro: SCHOOLBOOK_MODRED_ZERO_CHK_EN.
- With it defined:
  - at accept, if m==0 the block goes straight to DONE on the next edge with r=0 and err=1 (no RUN);
  - err is cleared on the next accept.
- Without it:
  - err is tied to 0;
  - m==0 runs the full 2N cycles;
  - r = c[N-1:0] (every compare is true and each subtraction is of zero), which is deterministic but meaningless.

Decomposition:
- Shared package schoolbook_pkg holds:
  - default width constant N_DEF=384;
  - counter width function/constant CNT_W = clog2(2N);
  - state enum {IDLE, RUN, DONE}.
- One natural sub-module, schoolbook_modred_step. It is purely combinational: shift-in, compare, conditional subtract on N+1 bits. This isolates the critical path for later unrolling to 2 bits per cycle.

Test Plan:
- N=8, c=16'hFFFF, m=8'd251, out_ready=1 -> out_valid rises 16 edges after accept; r=8'd24; err=0.
- N=384, c=100, m=7 -> r=2 after exactly 768 cycles. Then back-to-back c=(2^384-1)^2, m=2^384-1 -> r=0. Both cases: in_ready low throughout RUN/DONE.
- m=1 with random c -> r=0. c=0 with random m -> r=0. c=m-1 (upper half zero) -> r=m-1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> r and out_valid stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next edge.
- Assert rst for 1 cycle at count=200 mid-RUN -> next cycle IDLE, in_ready=1, out_valid=0, r=0. A new operation then completes correctly with full latency.
- m=0 with macro -> out_valid one edge after accept, r=0, err=1. Next valid op clears err. m=0 without macro -> r=c[N-1:0] after 2N cycles, err=0.
